state_frame_tx: RTL and testbench
=================================

STATE_FRAME_TX -- requirements
Module: state_frame_tx

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock; same clock that drives the CPU core.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: capture  input  1  one-cycle request to snapshot state_vector.
REQ-005 Port: state_vector  input  131  packed CPU state: [130] dummy, [129:114] Reg0, [113:98] Reg1, [97:82] Reg2, [81:66] Reg3, [65:50] Reg4, [49:34] Reg5, [33:18] Reg6, [17:2] Reg7, [1] Zero, [0] Carry.
REQ-006 Port: tx_data  output  16  current frame word.
REQ-007 Port: tx_valid  output  1  tx_data is valid.
REQ-008 Port: tx_ready  input  1  sink accepts the word; a transfer occurs when tx_valid && tx_ready.
REQ-009 Port: tx_last  output  1  high with the final word of a frame.
REQ-010 Port: busy  output  1  a frame is in flight or a snapshot is pending.
REQ-011 Port: drop_count  output  8  saturating count of discarded captures.

Function
REQ-012 Frame SHALL be 10 words: W0 = {8'hA5, seq[7:0]}; W1..W8 = Reg0..Reg7; W9 = {13'b0, dummy, Zero, Carry}.
REQ-013 FSM SHALL have states IDLE and SEND, with a 4-bit word index of 0..9.
REQ-014 In IDLE, capture=1 SHALL latch state_vector into the active snapshot; the FSM enters SEND and tx_valid rises on the next cycle (latency 1) with W0.
REQ-015 In SEND, tx_data, tx_valid and tx_last SHALL hold stable while tx_valid && !tx_ready.
REQ-016 Each transfer SHALL advance the index by 1; tx_last = 1 exactly when index = 9.
REQ-017 When W9 transfers and no snapshot is pending, the FSM SHALL return to IDLE and tx_valid SHALL be low the next cycle.
REQ-018 When W9 transfers and a snapshot is pending, that snapshot SHALL move to active and W0 of the next frame SHALL be presented the next cycle (no idle bubble).
REQ-019 Pending buffer: one entry. A capture in SEND with the pending slot empty SHALL store state_vector into the pending slot.
REQ-020 A capture in SEND with the pending slot full SHALL be discarded, and drop_count SHALL increment, saturating at 255.
REQ-021 Capture in the same cycle as the W9 transfer:
  - the pending slot frees and the capture is stored as pending;
  - this case SHALL NOT count as a drop.
REQ-022 seq SHALL be 0 for the first frame after reset, SHALL increment by 1 per frame started, and SHALL wrap from 255 to 0.
REQ-023 busy SHALL be 1 in SEND or while the pending slot is full, and 0 otherwise.
REQ-024 The snapshot SHALL reflect state_vector exactly as sampled on the capture cycle; later changes to state_vector SHALL NOT affect the frame.

Reset
REQ-025 While rst=1, all outputs SHALL be 0 on the next edge: tx_valid, tx_last, busy, tx_data and drop_count. State SHALL be FSM=IDLE, index=0, pending cleared, seq=0.
REQ-026 rst asserted mid-frame SHALL abort the frame with no further words and no tx_last.
REQ-027 A capture in the same cycle as rst SHALL be ignored.

Structure
REQ-028 Package state_frame_pkg SHALL hold:
  - SYNC_BYTE = 8'hA5
  - FRAME_WORDS = 10
  - the state_vector field bit positions
  - the FSM state enum
REQ-029 Sub-module snapshot_slot (131-bit register with valid flag, load and clear) SHALL be instantiated twice: once as the active slot and once as the pending slot.

Verification
REQ-030 Scenario 1: Reg0..Reg7 = 16'h0001..16'h0008, Z=1, C=0, dummy=0, tx_ready held at 1, one capture -> 10 consecutive words A500, 0001..0008, 0002; tx_last only on the 10th word; busy falls the cycle after that word.
REQ-031 Scenario 2: backpressure with tx_ready toggling 1,0,0,1,... -> no word is skipped or duplicated, and tx_data is stable during every stall.
REQ-032 Scenario 3: three captures during one frame with tx_ready=0 -> the second capture is pending, the third makes drop_count=1, and a second frame starting A501 follows back-to-back.
REQ-033 Scenario 4: capture coincident with the W9 transfer while pending is full -> drop_count unchanged, and the next two frames carry seq n+1 and n+2.
REQ-034 Scenario 5: 256 frames -> the 257th header is A500; 300 forced drops -> drop_count=255.
REQ-035 Scenario 6: rst at word index 4 -> tx_valid=0 and drop_count=0 next cycle; the next capture yields header A500.

Source files
------------

// File: rtl/state_frame_pkg.sv
// state_frame_pkg: frame constants, CPU state field positions, FSM states and word mux.
package state_frame_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int FRAME_WORDS = 10;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_WORDS - 1);
  localparam int SV_W = 131;
  localparam int REG_W = 16;
  localparam int DUMMY_BIT = 130;
  localparam int REG0_MSB = 129;
  localparam int REG7_LSB = 2;
  localparam int ZERO_BIT = 1;
  localparam int CARRY_BIT = 0;
  typedef enum logic {IDLE, SEND} state_t;
  // Reg0 sits in the top lane of the register block, so word k maps to lane 8-k.
  function automatic logic [15:0] frame_word(input logic [SV_W-1:0] sv, input logic [3:0] idx, input logic [7:0] seq);
    logic [7:0][REG_W-1:0] regs;
    regs = sv[REG0_MSB:REG7_LSB];
    return idx == 4'd0 ? {SYNC_BYTE, seq} :
           idx == LAST_IDX ? {13'b0, sv[DUMMY_BIT], sv[ZERO_BIT], sv[CARRY_BIT]} :
           regs[3'(4'd8 - idx)];
  endfunction
endpackage

// File: rtl/state_frame_tx_snapshot_slot.sv
// snapshot_slot: one captured CPU state with a valid flag; load wins over clear.
module snapshot_slot
  import state_frame_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [SV_W-1:0] i_data,
  output logic [SV_W-1:0] o_data,
  output logic            o_valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_data <= i_data;
      o_valid <= 1'b1;
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/state_frame_tx.sv
// state_frame_tx: serialises CPU state snapshots into 10-word frames with
// one pending snapshot of look-ahead and a saturating drop counter.
module state_frame_tx
  import state_frame_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic [SV_W-1:0] state_vector,
  output logic [15:0]     tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            tx_last,
  output logic            busy,
  output logic [7:0]      drop_count
);
  state_t r_state;
  logic [3:0] r_idx;
  logic [7:0] r_seq;
  logic w_send, w_xfer, w_end, w_act_load, w_pnd_load, w_drop;
  logic w_act_valid, w_pnd_valid;
  logic [SV_W-1:0] w_act_data, w_pnd_data, w_act_din;
  logic [3:0] w_idx_nx;
  // A capture on the final transfer with nothing pending starts the next frame directly.
  always_comb begin
    w_send = r_state == SEND;
    w_xfer = tx_valid && tx_ready;
    w_end = w_xfer && r_idx == LAST_IDX;
    w_act_load = (capture && !w_send) || (w_end && (w_pnd_valid || capture));
    w_act_din = (w_end && w_pnd_valid) ? w_pnd_data : state_vector;
    w_pnd_load = capture && w_send && (w_end == w_pnd_valid);
    w_drop = capture && w_send && !w_end && w_pnd_valid;
    w_idx_nx = r_idx + 4'd1;
    busy = w_act_valid || w_pnd_valid;
  end
  snapshot_slot u_active (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_act_load),
    .i_clear (w_end),
    .i_data  (w_act_din),
    .o_data  (w_act_data),
    .o_valid (w_act_valid)
  );
  snapshot_slot u_pending (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_pnd_load),
    .i_clear (w_end),
    .i_data  (state_vector),
    .o_data  (w_pnd_data),
    .o_valid (w_pnd_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_seq <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      tx_last <= 1'b0;
      drop_count <= '0;
    end else begin
      if (w_act_load) begin
        r_state <= SEND;
        r_idx <= '0;
        r_seq <= r_seq + 8'd1;
        tx_data <= frame_word(w_act_din, 4'd0, r_seq);
        tx_valid <= 1'b1;
        tx_last <= 1'b0;
      end else if (w_end) begin
        r_state <= IDLE;
        r_idx <= '0;
        tx_data <= '0;
        tx_valid <= 1'b0;
        tx_last <= 1'b0;
      end else if (w_xfer) begin
        r_idx <= w_idx_nx;
        tx_data <= frame_word(w_act_data, w_idx_nx, r_seq);
        tx_last <= w_idx_nx == LAST_IDX;
      end
      if (w_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_state_frame_tx.sv
// tb_state_frame_tx: random and directed frames scored against a frame-queue model.
module tb_state_frame_tx;
  logic clk = 1'b0;
  logic rst, capture, tx_ready, tx_valid, tx_last, busy;
  logic [130:0] state_vector;
  logic [15:0] tx_data;
  logic [7:0] drop_count;
  int vectors = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] log_q[$];
  logic [15:0] hdr_q[$];
  int occ = 0;
  int sent = 0;
  int m_drop = 0;
  logic [7:0] m_seq = 8'd0;
  bit checking = 1'b0;
  bit prev_stall = 1'b0;
  logic [15:0] prev_data = 16'd0;
  logic [15:0] s1_words [10] = '{16'hA500, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0002};

  state_frame_tx dut (
    .clk          (clk),
    .rst          (rst),
    .capture      (capture),
    .state_vector (state_vector),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_last      (tx_last),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [130:0] sv, input int k, input logic [7:0] seq);
    logic [130:0] t;
    if (k == 0) return {8'hA5, seq};
    if (k == 9) return {13'b0, sv[130], sv[1], sv[0]};
    t = sv >> (2 + 16 * (8 - k));
    return t[15:0];
  endfunction

  // Model: frames are a queue of at most two (in flight + waiting); the
  // in-flight frame leaves on its tenth transfer, before a same-edge capture is judged.
  task automatic step(input bit c, input bit r, input bit rs, input bit fixed);
    logic [159:0] t;
    capture = c;
    tx_ready = r;
    rst = rs;
    if (!fixed) begin
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      state_vector = t[130:0];
    end
    @(posedge clk);
    if (rs) begin
      occ = 0;
      sent = 0;
      m_seq = 8'd0;
      m_drop = 0;
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (occ > 0 && r) begin
        if (sent == 9) begin
          sent = 0;
          occ--;
        end else sent++;
      end
      if (c) begin
        if (occ < 2) begin
          for (int k = 0; k < 10; k++) exp_q.push_back(word_of(state_vector, k, m_seq));
          m_seq++;
          occ++;
        end else if (m_drop < 255) m_drop++;
      end
    end
    #1;
  endtask

  task automatic check_hdr(input string name, input int i, input logic [15:0] req);
    if (hdr_q.size() > i) check(name, 32'(hdr_q[i]), 32'(req));
    else begin
      vectors++;
      errors++;
      $display("FAIL %s: only %0d headers seen, expected header %0h at %0d", name, hdr_q.size(), req, i);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("tx_valid", 32'(tx_valid), 32'(occ > 0));
      check("tx_last", 32'(tx_last), 32'(occ > 0 && sent == 9));
      check("busy", 32'(busy), 32'(occ > 0));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      if (prev_stall) check("stall_hold", 32'(tx_data), 32'(prev_data));
      if (tx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL tx_data: got %0h, expected no word", tx_data);
        end else begin
          check("tx_data", 32'(tx_data), 32'(exp_q[0]));
          if (tx_ready) begin
            log_q.push_back(tx_data);
            if (sent == 0) hdr_q.push_back(tx_data);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  initial begin
    capture = 1'b0;
    tx_ready = 1'b0;
    rst = 1'b1;
    state_vector = '0;
    step(0, 0, 1, 0);
    checking = 1'b1;
    step(1, 0, 1, 0);
    check("reset_data", 32'(tx_data), 32'd0);
    // Scenario 1: known registers, ready held high
    state_vector = {1'b0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                    16'h0006, 16'h0007, 16'h0008, 1'b1, 1'b0};
    log_q.delete();
    step(1, 1, 0, 1);
    repeat (12) step(0, 1, 0, 0);
    check("s1_count", 32'(log_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < log_q.size(); i++) check("s1_word", 32'(log_q[i]), 32'(s1_words[i]));
    // Scenario 2: 1,0,0,1 backpressure
    step(1, 1, 0, 0);
    for (int i = 0; i < 40; i++) step(0, (i % 4 == 0) || (i % 4 == 3), 0, 0);
    // Scenario 3: three captures while stalled
    step(0, 0, 1, 0);
    hdr_q.delete();
    repeat (3) step(1, 0, 0, 0);
    check("s3_drop", 32'(drop_count), 32'd1);
    repeat (25) step(0, 1, 0, 0);
    check_hdr("s3_hdr0", 0, 16'hA500);
    check_hdr("s3_hdr1", 1, 16'hA501);
    // Scenario 4: capture on the final transfer with pending full
    step(0, 0, 1, 0);
    hdr_q.delete();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 40 && !(occ == 2 && sent == 9); i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("s4_drop", 32'(drop_count), 32'd0);
    repeat (25) step(0, 1, 0, 0);
    check_hdr("s4_hdr1", 1, 16'hA501);
    check_hdr("s4_hdr2", 2, 16'hA502);
    // Scenario 5: sequence wrap and drop saturation
    step(0, 0, 1, 0);
    hdr_q.delete();
    repeat (2650) step(1, 1, 0, 0);
    check("s5_drop_sat", 32'(drop_count), 32'd255);
    check_hdr("s5_hdr255", 255, 16'hA5FF);
    check_hdr("s5_hdr256", 256, 16'hA500);
    // Scenario 6: reset mid-frame with a coincident capture
    step(0, 0, 1, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 20 && sent != 4; i++) step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    check("s6_valid", 32'(tx_valid), 32'd0);
    check("s6_last", 32'(tx_last), 32'd0);
    check("s6_data", 32'(tx_data), 32'd0);
    check("s6_drop", 32'(drop_count), 32'd0);
    hdr_q.delete();
    step(1, 1, 0, 0);
    repeat (12) step(0, 1, 0, 0);
    check_hdr("s6_hdr", 0, 16'hA500);
    // Random traffic with occasional resets
    repeat (3000) step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0, 0);
    repeat (25) step(0, 1, 0, 0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
